// File: rtl/ddr_rpath_pkg.sv
// Shared constants, state encoding and helpers for the DDR read data path.
package ddr_rpath_pkg;

    localparam int DQ_WIDTH     = 32;
    localparam int RFIFO_WIDTH  = 2 * DQ_WIDTH;
    localparam int RFIFO_D0_LSB = 0;
    localparam int RFIFO_D1_LSB = DQ_WIDTH;

    typedef enum logic {
        RPATH_IDLE  = 1'b0,
        RPATH_BURST = 1'b1
    } rpath_state_e;

    // Beat index of the final strobe in a burst of the given length.
    function automatic logic [2:0] last_beat(input int burst_beats);
        return 3'(burst_beats - 1);
    endfunction

endpackage

// File: rtl/ddr_rfifo.sv
// Single-clock show-ahead FIFO; the head word is always driven on dout_o (zero while empty).
module ddr_rfifo #(
    parameter int W  = 64,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = level_o[AW];
    assign empty_o = (level_o == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define what is valid, and dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ddr_rpath.sv
// DDR read data path: captures beat pairs on sample, frames bursts, buffers words for Wishbone.
// Define DDR_RPATH_CAPTURE_REG_EN to add one register stage on sample/dq_rise/dq_fall.
module ddr_rpath import ddr_rpath_pkg::*; #(
    parameter int DQ_W        = DQ_WIDTH,
    parameter int FIFO_AW     = 4,
    parameter int BURST_BEATS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample,
    input  logic [DQ_W-1:0]   dq_rise,
    input  logic [DQ_W-1:0]   dq_fall,
    output logic [2*DQ_W-1:0] rdata_dout,
    output logic              rdata_valid,
    input  logic              rdata_ack,
    output logic [FIFO_AW:0]  rdata_level,
    output logic              burst_done,
    output logic              overflow,
    output logic              burst_err
);

    localparam logic [2:0] LAST = last_beat(BURST_BEATS);

    logic            sample_s;
    logic [DQ_W-1:0] rise_s;
    logic [DQ_W-1:0] fall_s;

`ifdef DDR_RPATH_CAPTURE_REG_EN
    logic            sample_q;
    logic [DQ_W-1:0] rise_q;
    logic [DQ_W-1:0] fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            sample_q <= sample;
            rise_q   <= dq_rise;
            fall_q   <= dq_fall;
        end
    end

    assign sample_s = sample_q;
    assign rise_s   = rise_q;
    assign fall_s   = fall_q;
`else
    assign sample_s = sample;
    assign rise_s   = dq_rise;
    assign fall_s   = dq_fall;
`endif

    logic fifo_full;
    logic fifo_empty;

    ddr_rfifo #(
        .W  (2 * DQ_W),
        .AW (FIFO_AW)
    ) u_rfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (sample_s),
        .pop_i   (rdata_ack),
        .din_i   ({fall_s, rise_s}),
        .dout_o  (rdata_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (rdata_level)
    );

    assign rdata_valid = ~fifo_empty;

    rpath_state_e state_q;
    logic [2:0]   cnt_q;
    logic         burst_done_q;
    logic         burst_err_q;
    logic         overflow_q;

    // NOTE: all state here is sequential, so every assignment in this block is non-blocking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RPATH_IDLE;
            cnt_q        <= '0;
            burst_done_q <= 1'b0;
            burst_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            // A full FIFO can only be popped, never empty, so ack alone decides whether a slot frees up.
            if (sample_s && fifo_full && !rdata_ack) overflow_q <= 1'b1;

            case (state_q)
                RPATH_IDLE: begin
                    if (sample_s) begin
                        if (LAST == 3'd0) begin
                            burst_done_q <= 1'b1;
                        end else begin
                            state_q <= RPATH_BURST;
                            cnt_q   <= 3'd1;
                        end
                    end
                end
                RPATH_BURST: begin
                    if (!sample_s) begin
                        burst_err_q <= 1'b1;
                        state_q     <= RPATH_IDLE;
                        cnt_q       <= '0;
                    end else if (cnt_q == LAST) begin
                        burst_done_q <= 1'b1;
                        state_q      <= RPATH_IDLE;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= RPATH_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign burst_done = burst_done_q;
    assign burst_err  = burst_err_q;
    assign overflow   = overflow_q;

endmodule
